// File: rtl/run_ctrl.sv
// run_ctrl: sequences CPU reset/run, detects halt marker or cycle budget, injects timed interrupts
module run_ctrl #(
  parameter int RST_CYCLES  = 3,
  parameter int MAX_CYCLES  = 3750,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter     HALT_PC     = 32'h0000_3ffc,
  parameter int HALT_REPEAT = 2,
  parameter int IRQ_CH      = 1,
  parameter int IRQ_LEN     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pc_valid,
  input  logic [PC_W-1:0]         pc_i,
  input  logic [IRQ_CH-1:0]       irq_en,
  input  logic [IRQ_CH*CNT_W-1:0] irq_at,
  output logic                    cpu_reset,
  output logic                    running,
  output logic                    done,
  output logic                    halted,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [IRQ_CH-1:0]       irq_o
);
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  localparam int RC = RST_CYCLES < 1 ? 1 : RST_CYCLES;
  localparam int IL = IRQ_LEN < 1 ? 1 : IRQ_LEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);
  state_t state_q, state_d;
  logic run_q, done_q, halted_q, timeout_q;
  logic [31:0] rst_q, hits_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IRQ_CH-1:0] irq_q, fire;
  logic [31:0] rem_q [IRQ_CH];
  logic halt_now, time_now, halt_hit, launch;
  always_comb begin
    halt_now = hits_q >= 32'(HALT_REPEAT);
    time_now = cnt_q == LAST;
    halt_hit = pc_valid && pc_i == PC_W'(HALT_PC);
    state_d = (state_q == IDLE || state_q == DONE) ? (start ? RST : state_q)
            : state_q == RST ? (rst_q == 32'(RC - 1) ? RUN : RST)
            : (halt_now || time_now) ? DONE : RUN;
    launch = state_d == RST && state_q != RST;
    fire = '0;
    for (int k = 0; k < IRQ_CH; k++)
      fire[k] = state_q == RUN && irq_en[k] && cnt_q == irq_at[k*CNT_W +: CNT_W];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      rst_q     <= '0;
      hits_q    <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= '0;
      for (int k = 0; k < IRQ_CH; k++) rem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= state_d == RUN;
      done_q  <= state_d == DONE;
      if (launch) begin
        rst_q     <= '0;
        hits_q    <= '0;
        cnt_q     <= '0;
        halted_q  <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state_q == RST) rst_q <= rst_q + 1;
      if (state_q == RUN) begin
        if (halt_hit && !halt_now) hits_q <= hits_q + 1;
        if (state_d == RUN) cnt_q <= cnt_q + 1;
        halted_q  <= halt_now;
        timeout_q <= !halt_now && time_now;
      end
      // a pulse lives only while the next state stays RUN
      for (int k = 0; k < IRQ_CH; k++) begin
        if (state_d != RUN) begin
          irq_q[k] <= 1'b0;
          rem_q[k] <= '0;
        end else if (fire[k]) begin
          irq_q[k] <= 1'b1;
          rem_q[k] <= 32'(IL - 1);
        end else if (irq_q[k]) begin
          irq_q[k] <= rem_q[k] != 0;
          rem_q[k] <= rem_q[k] != 0 ? rem_q[k] - 1 : '0;
        end
      end
    end
  end
  assign cpu_reset = !run_q;
  assign running   = run_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;
  assign irq_o     = irq_q;
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 3: cycles the CPU reset is held after start.
REQ-002 SHALL have parameter MAX_CYCLES, default 3750: run-cycle budget before timeout.
REQ-003 SHALL have parameter CNT_W, default 32: cycle counter width; MAX_CYCLES < 2^CNT_W.
REQ-004 SHALL have parameter PC_W, default 32: retired-PC width.
REQ-005 SHALL have parameter HALT_PC, default 32'h0000_3ffc: halt-marker PC.
REQ-006 SHALL have parameter HALT_REPEAT, default 2: HALT_PC retirements that declare halt.
REQ-007 SHALL have parameter IRQ_CH, default 1: interrupt injection channel count.
REQ-008 SHALL have parameter IRQ_LEN, default 1: cycles each injected interrupt is held high.
REQ-009 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-010 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-011 SHALL have port start, input, 1: starts a run.
REQ-012 SHALL have port pc_valid, input, 1: one instruction retired this cycle.
REQ-013 SHALL have port pc_i, input, PC_W: PC of the retired instruction.
REQ-014 SHALL have port irq_en, input, IRQ_CH: per-channel injection enable.
REQ-015 SHALL have port irq_at, input, IRQ_CH*CNT_W: per-channel trigger cycle; channel k at bits [k*CNT_W +: CNT_W].
REQ-016 SHALL have port cpu_reset, output, 1: reset to the CPU under control.
REQ-017 SHALL have port running, output, 1: high in RUN.
REQ-018 SHALL have port done, output, 1: high in DONE.
REQ-019 SHALL have port halted, output, 1: run ended by the halt marker.
REQ-020 SHALL have port timeout, output, 1: run ended by the cycle budget.
REQ-021 SHALL have port cycle_cnt, output, CNT_W: number of RUN cycles elapsed.
REQ-022 SHALL have port irq_o, output, IRQ_CH: injected interrupt lines.

Function
REQ-023 SHALL implement FSM states IDLE, RST, RUN and DONE, with outputs registered.
REQ-024 SHALL drive cpu_reset=1 in IDLE, RST and DONE, and cpu_reset=0 only in RUN.
REQ-025 SHALL move IDLE->RST on start and clear cycle_cnt, halted, timeout and the halt-hit counter.
REQ-026 SHALL hold RST for exactly RST_CYCLES cycles and then enter RUN; RST_CYCLES=0 SHALL be treated as 1.
REQ-027 SHALL present cycle_cnt=0 in the first RUN cycle and increment it by 1 each subsequent RUN cycle.
REQ-028 SHALL increment the halt-hit counter each RUN cycle with pc_valid=1 and pc_i==HALT_PC; hits need not be consecutive.
REQ-029 SHALL go to DONE with halted=1 on the cycle after the hit counter reaches HALT_REPEAT.
REQ-030 SHALL go to DONE with timeout=1 on the cycle after cycle_cnt==MAX_CYCLES-1 is observed in RUN.
REQ-031 SHALL give halt priority over timeout when both occur in the same cycle: halted=1, timeout=0.
REQ-032 SHALL freeze cycle_cnt, halted and timeout in DONE.
REQ-033 SHALL move DONE->RST on start and clear as in REQ-025.
REQ-034 SHALL ignore start in RST and RUN.
REQ-035 SHALL, per channel k, drive irq_o[k]=1 for IRQ_LEN consecutive cycles from the cycle after a RUN cycle in which irq_en[k]=1 and cycle_cnt==irq_at[k].
REQ-036 SHALL fire each channel at most once per run, with channels fully independent of each other.
REQ-037 SHALL force irq_o to 0 in every state other than RUN and cut any pulse still in progress when RUN exits.
REQ-038 SHALL never fire a channel whose irq_at >= MAX_CYCLES.

Reset
REQ-039 SHALL, on reset=1, synchronously enter IDLE from any state, including mid-RUN, with cpu_reset=1, running=0, done=0, halted=0, timeout=0, cycle_cnt=0, irq_o=0 and all internal counters 0.
REQ-040 SHALL give reset priority over start when both are asserted in the same cycle.

Verification
REQ-041 SHALL check, with defaults: start pulse -> cpu_reset high for 3 cycles, then running=1 with cycle_cnt=0,1,2,...
REQ-042 SHALL check, with defaults: two pc_valid retirements of 0x3ffc at cycle_cnt 10 and 12 -> done=1, halted=1, timeout=0, cycle_cnt frozen at 13.
REQ-043 SHALL check, with defaults: no halt PC presented -> done=1 with timeout=1 after cycle_cnt 3749, and cpu_reset=1 thereafter.
REQ-044 SHALL check, with IRQ_CH=2 and IRQ_LEN=3: irq_at={20,5} with both channels enabled -> irq_o[0] high for cycles after cnt 5-7, irq_o[1] high for cycles after cnt 20-22, and never again in that run.
REQ-045 SHALL check: reset asserted at cycle_cnt 100 with irq_o high -> the next cycle shows IDLE outputs, irq_o=0 and cycle_cnt=0.
REQ-046 SHALL check: halt reached and timeout at the same edge -> halted=1, timeout=0; a following start in DONE re-enters RST with all flags cleared.
